// File: rtl/switch_input_buffer.sv
// Per-link switch input stage: NUM_VCS independent flit FIFOs with registered head
// presentation, per-VC packet framing tracking and one credit returned per dequeued flit.
module switch_input_buffer #(
   parameter int unsigned NUM_VCS     = 2,
   parameter int unsigned BUFFER_SIZE = 8,
   parameter int unsigned FLIT_WIDTH  = 32
) (
   input  logic                                          clk,
   input  logic                                          n_rst,
   input  logic                                          in_valid,
   input  logic [((NUM_VCS > 1) ? $clog2(NUM_VCS) : 1)-1:0] in_vc,
   input  logic [FLIT_WIDTH-1:0]                         in_flit,
   output logic [NUM_VCS-1:0]                            head_valid,
   output logic [NUM_VCS-1:0]                            head_is_header,
   output logic [NUM_VCS*FLIT_WIDTH-1:0]                 head_flit,
   input  logic [NUM_VCS-1:0]                            pop,
   output logic [NUM_VCS-1:0]                            credit_return,
   output logic [NUM_VCS*($clog2(BUFFER_SIZE)+1)-1:0]    occupancy,
   output logic                                          overflow
);

   localparam int unsigned VC_W  = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1;
   localparam int unsigned PTR_W = $clog2(BUFFER_SIZE);
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam int unsigned LEN_W = 4;

   typedef enum logic {EXPECT_HDR = 1'b0, IN_BODY = 1'b1} frame_state_t;

   logic [FLIT_WIDTH-1:0] mem [NUM_VCS][BUFFER_SIZE];

   logic [PTR_W-1:0]      rd_q   [NUM_VCS];
   logic [PTR_W-1:0]      rd_d   [NUM_VCS];
   logic [PTR_W-1:0]      wr_q   [NUM_VCS];
   logic [PTR_W-1:0]      wr_d   [NUM_VCS];
   logic [CNT_W-1:0]      cnt_q  [NUM_VCS];
   logic [CNT_W-1:0]      cnt_d  [NUM_VCS];
   logic [CNT_W-1:0]      left   [NUM_VCS];
   frame_state_t          state_q[NUM_VCS];
   frame_state_t          state_d[NUM_VCS];
   logic [LEN_W-1:0]      rem_q  [NUM_VCS];
   logic [LEN_W-1:0]      rem_d  [NUM_VCS];
   logic [FLIT_WIDTH-1:0] head_q [NUM_VCS];
   logic [FLIT_WIDTH-1:0] head_d [NUM_VCS];

   logic [NUM_VCS-1:0] do_pop;
   logic [NUM_VCS-1:0] do_wr;
   logic [NUM_VCS-1:0] sel;
   logic [NUM_VCS-1:0] head_valid_d;
   logic [NUM_VCS-1:0] head_is_header_d;
   logic [NUM_VCS-1:0] credit_d;
   logic               overflow_d;

   // Next-state: pointers, counts, framing and the registered head copy per VC
   always_comb begin
      overflow_d = overflow;
      for (int v = 0; v < NUM_VCS; v++) begin
         rd_d[v]             = rd_q[v];
         wr_d[v]             = wr_q[v];
         cnt_d[v]            = cnt_q[v];
         state_d[v]          = state_q[v];
         rem_d[v]            = rem_q[v];
         head_d[v]           = head_q[v];
         left[v]             = cnt_q[v];
         head_valid_d[v]     = 1'b0;
         head_is_header_d[v] = 1'b0;
         credit_d[v]         = 1'b0;

         sel[v]    = in_valid && ((NUM_VCS == 1) || (in_vc == VC_W'(v)));
         do_pop[v] = pop[v] && (cnt_q[v] != '0);
         // a pop on a full VC frees the slot before the write lands
         do_wr[v]  = sel[v] && ((cnt_q[v] != CNT_W'(BUFFER_SIZE)) || do_pop[v]);
         if (sel[v] && !do_wr[v]) overflow_d = 1'b1;

         if (do_pop[v]) begin
            left[v] = cnt_q[v] - CNT_W'(1);
            rd_d[v] = rd_q[v] + PTR_W'(1);
         end
         cnt_d[v] = left[v];
         if (do_wr[v]) begin
            cnt_d[v] = left[v] + CNT_W'(1);
            wr_d[v]  = wr_q[v] + PTR_W'(1);
         end

         if (do_pop[v]) begin
            if (state_q[v] == EXPECT_HDR) begin
               if (head_q[v][FLIT_WIDTH-1 -: LEN_W] > LEN_W'(1)) begin
                  rem_d[v]   = head_q[v][FLIT_WIDTH-1 -: LEN_W] - LEN_W'(1);
                  state_d[v] = IN_BODY;
               end
            end else if (rem_q[v] <= LEN_W'(1)) begin
               rem_d[v]   = '0;
               state_d[v] = EXPECT_HDR;
            end else begin
               rem_d[v] = rem_q[v] - LEN_W'(1);
            end
         end

         // the slot being written becomes the head only when nothing older remains
         if (do_wr[v] && (left[v] == '0)) begin
            head_d[v] = in_flit;
         end else if (cnt_d[v] == '0) begin
            head_d[v] = '0;
         end else begin
            head_d[v] = mem[v][rd_d[v]];
         end

         head_valid_d[v]     = (cnt_d[v] != '0);
         head_is_header_d[v] = (cnt_d[v] != '0) && (state_d[v] == EXPECT_HDR);
         credit_d[v]         = do_pop[v];
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (n_rst) begin
         for (int v = 0; v < NUM_VCS; v++) begin
            rd_q[v]    <= '0;
            wr_q[v]    <= '0;
            cnt_q[v]   <= '0;
            state_q[v] <= EXPECT_HDR;
            rem_q[v]   <= '0;
            head_q[v]  <= '0;
         end
         head_valid     <= '0;
         head_is_header <= '0;
         credit_return  <= '0;
         overflow       <= 1'b0;
      end else begin
         for (int v = 0; v < NUM_VCS; v++) begin
            rd_q[v]    <= rd_d[v];
            wr_q[v]    <= wr_d[v];
            cnt_q[v]   <= cnt_d[v];
            state_q[v] <= state_d[v];
            rem_q[v]   <= rem_d[v];
            head_q[v]  <= head_d[v];
         end
         head_valid     <= head_valid_d;
         head_is_header <= head_is_header_d;
         credit_return  <= credit_d;
         overflow       <= overflow_d;
      end
   end

   // Flit storage, no reset needed: contents are only read behind the count
   always_ff @(posedge clk) begin
      for (int v = 0; v < NUM_VCS; v++) begin
         if (!n_rst && do_wr[v]) mem[v][wr_q[v]] <= in_flit;
      end
   end

   always_comb begin
      head_flit = '0;
      occupancy = '0;
      for (int v = 0; v < NUM_VCS; v++) begin
         head_flit[v*FLIT_WIDTH +: FLIT_WIDTH] = head_q[v];
         occupancy[v*CNT_W +: CNT_W]           = cnt_q[v];
      end
   end

endmodule

// File: tb/tb_switch_input_buffer.sv
// Bench for switch_input_buffer: vector table, directed corner sequences and random
// traffic checked against a queue-based packet model.
module tb_switch_input_buffer;

   logic        clk = 1'b0;
   logic        n_rst;
   logic        in_valid;
   logic [0:0]  in_vc;
   logic [31:0] in_flit;
   logic [1:0]  head_valid;
   logic [1:0]  head_is_header;
   logic [63:0] head_flit;
   logic [1:0]  pop;
   logic [1:0]  credit_return;
   logic [7:0]  occupancy;
   logic        overflow;

   always #5 clk = ~clk;

   switch_input_buffer #(.NUM_VCS(2), .BUFFER_SIZE(8), .FLIT_WIDTH(32)) dut (
      .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_vc(in_vc), .in_flit(in_flit),
      .head_valid(head_valid), .head_is_header(head_is_header), .head_flit(head_flit),
      .pop(pop), .credit_return(credit_return), .occupancy(occupancy), .overflow(overflow)
   );

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: one queue per VC, flits left in the current packet, sticky drop flag
   logic [31:0] mq [2][$];
   int          rem [2];
   logic        m_ovf;
   logic [1:0]  m_cr;

   typedef struct {
      logic        iv;
      logic        vc;
      logic [31:0] flit;
      logic [1:0]  pop;
      logic [1:0]  hv;
      logic [1:0]  hh;
      logic [1:0]  cr;
      logic [7:0]  occ;
      logic [63:0] head;
   } vec_t;

   vec_t vecs [12];

   function automatic vec_t mk(logic iv, logic vc, logic [31:0] f, logic [1:0] p, logic [1:0] hv,
                               logic [1:0] hh, logic [1:0] cr, logic [7:0] occ, logic [63:0] head);
      vec_t r;
      r.iv = iv; r.vc = vc; r.flit = f; r.pop = p;
      r.hv = hv; r.hh = hh; r.cr = cr; r.occ = occ; r.head = head;
      return r;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_clear();
      mq[0].delete();
      mq[1].delete();
      rem[0] = 0;
      rem[1] = 0;
      m_ovf  = 1'b0;
      m_cr   = 2'b00;
   endtask

   task automatic model_update(input logic iv, input logic vc, input logic [31:0] f,
                               input logic [1:0] p);
      logic [1:0]  popped;
      logic [31:0] front;
      int          len;
      for (int v = 0; v < 2; v++) popped[v] = p[v] && (mq[v].size() > 0);
      for (int v = 0; v < 2; v++) begin
         if (popped[v]) begin
            front = mq[v].pop_front();
            if (rem[v] == 0) begin
               len    = int'(front[31:28]);
               rem[v] = (len <= 1) ? 0 : len - 1;
            end else begin
               rem[v]--;
            end
         end
         if (iv && (int'(vc) == v)) begin
            if (mq[v].size() < 8) mq[v].push_back(f);
            else m_ovf = 1'b1;
         end
      end
      m_cr = popped;
   endtask

   task automatic check_model();
      int sz;
      for (int v = 0; v < 2; v++) begin
         sz = mq[v].size();
         chk($sformatf("head_valid[%0d]", v), 64'(head_valid[v]), 64'(sz > 0));
         chk($sformatf("head_is_header[%0d]", v), 64'(head_is_header[v]),
             64'((sz > 0) && (rem[v] == 0)));
         chk($sformatf("head_flit[%0d]", v), 64'(head_flit[v*32 +: 32]),
             (sz > 0) ? 64'(mq[v][0]) : 64'h0);
         chk($sformatf("credit_return[%0d]", v), 64'(credit_return[v]), 64'(m_cr[v]));
         chk($sformatf("occupancy[%0d]", v), 64'(occupancy[v*4 +: 4]), 64'(sz));
      end
      chk("overflow", 64'(overflow), 64'(m_ovf));
   endtask

   task automatic step(input logic iv, input logic vc, input logic [31:0] f, input logic [1:0] p);
      in_valid = iv;
      in_vc    = vc;
      in_flit  = f;
      pop      = p;
      @(posedge clk);
      #1;
      model_update(iv, vc, f, p);
      in_valid = 1'b0;
      pop      = 2'b00;
   endtask

   // Reset with live traffic on the inputs; nothing may leak through
   task automatic do_reset();
      n_rst    = 1'b1;
      in_valid = 1'b1;
      in_vc    = 1'($urandom_range(0, 1));
      in_flit  = $urandom;
      pop      = 2'b11;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_credit", 64'(credit_return), 64'h0);
      n_rst    = 1'b0;
      in_valid = 1'b0;
      pop      = 2'b00;
      model_clear();
      check_model();
   endtask

   initial begin
      int cr_cnt;
      int dut_cr_total;
      int mdl_cr_total;
      logic [1:0] p;

      n_rst = 1'b1; in_valid = 1'b0; in_vc = 1'b0; in_flit = '0; pop = 2'b00;
      model_clear();

      vecs[0]  = mk(1, 0, 32'h1000_00AB, 2'b00, 2'b01, 2'b01, 2'b00, 8'h01, 64'h0000_0000_1000_00AB);
      vecs[1]  = mk(0, 0, 32'h0,         2'b01, 2'b00, 2'b00, 2'b01, 8'h00, 64'h0);
      vecs[2]  = mk(0, 0, 32'h0,         2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 64'h0);
      vecs[3]  = mk(1, 1, 32'h3000_0001, 2'b00, 2'b10, 2'b10, 2'b00, 8'h10, 64'h3000_0001_0000_0000);
      vecs[4]  = mk(1, 1, 32'h0000_0002, 2'b00, 2'b10, 2'b10, 2'b00, 8'h20, 64'h3000_0001_0000_0000);
      vecs[5]  = mk(1, 1, 32'h0000_0003, 2'b00, 2'b10, 2'b10, 2'b00, 8'h30, 64'h3000_0001_0000_0000);
      vecs[6]  = mk(1, 1, 32'h1000_0004, 2'b00, 2'b10, 2'b10, 2'b00, 8'h40, 64'h3000_0001_0000_0000);
      vecs[7]  = mk(0, 0, 32'h0,         2'b10, 2'b10, 2'b00, 2'b10, 8'h30, 64'h0000_0002_0000_0000);
      vecs[8]  = mk(0, 0, 32'h0,         2'b10, 2'b10, 2'b00, 2'b10, 8'h20, 64'h0000_0003_0000_0000);
      vecs[9]  = mk(0, 0, 32'h0,         2'b10, 2'b10, 2'b10, 2'b10, 8'h10, 64'h1000_0004_0000_0000);
      vecs[10] = mk(0, 0, 32'h0,         2'b10, 2'b00, 2'b00, 2'b10, 8'h00, 64'h0);
      vecs[11] = mk(0, 0, 32'h0,         2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 64'h0);

      // Reset, single-flit packet, then a 3-flit packet followed by a header
      do_reset();
      for (int i = 0; i < 12; i++) begin
         step(vecs[i].iv, vecs[i].vc, vecs[i].flit, vecs[i].pop);
         chk($sformatf("tbl%0d_head_valid", i), 64'(head_valid), 64'(vecs[i].hv));
         chk($sformatf("tbl%0d_head_is_header", i), 64'(head_is_header), 64'(vecs[i].hh));
         chk($sformatf("tbl%0d_credit", i), 64'(credit_return), 64'(vecs[i].cr));
         chk($sformatf("tbl%0d_occupancy", i), 64'(occupancy), 64'(vecs[i].occ));
         chk($sformatf("tbl%0d_head_flit", i), head_flit, vecs[i].head);
      end
      chk("tbl_overflow", 64'(overflow), 64'h0);

      // Fill VC0, drop the ninth flit, then drain in order
      do_reset();
      for (int i = 0; i < 8; i++) begin
         step(1, 0, 32'h1000_00A0 + 32'(i), 2'b00);
         check_model();
      end
      chk("full_occupancy", 64'(occupancy[3:0]), 64'd8);
      step(1, 0, 32'hDEAD_BEEF, 2'b00);
      check_model();
      chk("overflow_set", 64'(overflow), 64'h1);
      chk("full_occupancy_after_drop", 64'(occupancy[3:0]), 64'd8);
      cr_cnt = 0;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("drain_order%0d", i), 64'(head_flit[31:0]), 64'(32'h1000_00A0 + 32'(i)));
         step(0, 0, 32'h0, 2'b01);
         cr_cnt += int'(credit_return[0]);
         check_model();
      end
      step(0, 0, 32'h0, 2'b01);
      cr_cnt += int'(credit_return[0]);
      chk("drain_credits", 64'(cr_cnt), 64'd8);
      chk("overflow_sticky", 64'(overflow), 64'h1);

      // Enqueue plus pop on a full VC is accepted without overflow
      do_reset();
      for (int i = 0; i < 8; i++) step(1, 1, 32'h1000_0B00 + 32'(i), 2'b00);
      step(1, 1, 32'h1000_0BFF, 2'b10);
      check_model();
      chk("full_enq_pop_occupancy", 64'(occupancy[7:4]), 64'd8);
      chk("full_enq_pop_overflow", 64'(overflow), 64'h0);
      for (int i = 0; i < 9; i++) begin
         step(0, 0, 32'h0, 2'b10);
         check_model();
      end

      // Random interleaved traffic with concurrent pops on both VCs
      do_reset();
      dut_cr_total = 0;
      mdl_cr_total = 0;
      for (int i = 0; i < 400; i++) begin
         p = 2'($urandom_range(0, 3));
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom, p);
         dut_cr_total += $countones(credit_return);
         mdl_cr_total += $countones(m_cr);
         check_model();
      end
      chk("random_credit_total", 64'(dut_cr_total), 64'(mdl_cr_total));

      // Reset in the middle of a 4-flit packet
      do_reset();
      step(1, 0, 32'h4000_0011, 2'b00);
      step(1, 0, 32'h0000_0022, 2'b00);
      step(0, 0, 32'h0, 2'b01);
      check_model();
      chk("midpkt_body_not_header", 64'(head_is_header[0]), 64'h0);
      do_reset();
      step(1, 0, 32'h2000_0033, 2'b00);
      chk("after_reset_header", 64'(head_is_header[0]), 64'h1);
      check_model();

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule
